// File: rtl/tile_line_fetch.sv
// Fetches one 8-pixel row of a 2bpp 8x8 tile from a registered-read tile ROM
// and streams it out as 2-bit colour indices, one pixel per accepted beat.
module tile_line_fetch #(
    parameter int TILE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [TILE_W-1:0] req_tile,
    input  logic [2:0]        req_row,
    input  logic              req_flip,
    output logic [TILE_W+3:0] rom_addr,
    output logic              rom_en,
    input  logic [7:0]        rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_color,
    output logic [2:0]        out_col,
    output logic              out_last
);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        CAP1,
        EMIT
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [TILE_W-1:0] tile_q;
    logic [2:0]        row_q;
    logic              flip_q;
    logic [7:0]        buf0;
    logic [7:0]        buf1;
    logic [2:0]        k;
    logic [TILE_W+3:0] addr_q;
    logic              en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            tile_q <= '0;
            row_q  <= '0;
            flip_q <= 1'b0;
            buf0   <= '0;
            buf1   <= '0;
            k      <= '0;
            addr_q <= '0;
            en_q   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        tile_q <= req_tile;
                        row_q  <= req_row;
                        flip_q <= req_flip;
                        addr_q <= {req_tile, req_row, 1'b0};
                        en_q   <= 1'b1;
                    end
                end
                RD0: begin
                    addr_q <= {tile_q, row_q, 1'b1};
                    en_q   <= 1'b1;
                end
                RD1: begin
                    // Half-0 byte returns now; the address is held, only enable drops.
                    buf0 <= rom_data;
                    en_q <= 1'b0;
                end
                CAP1: begin
                    buf1 <= rom_data;
                    k    <= '0;
                end
                EMIT: begin
                    if (out_ready) begin
                        k <= k + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = RD0;
            RD0:     state_nx = RD1;
            RD1:     state_nx = CAP1;
            CAP1:    state_nx = EMIT;
            EMIT:    if (out_ready && (k == 3'd7)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    logic [2:0] col;
    logic [7:0] sel_byte;
    logic [1:0] pix;

    always_comb begin
        col       = flip_q ? ~k : k;
        sel_byte  = col[2] ? buf1 : buf0;
        pix       = col[1:0];
        out_color = {sel_byte[{1'b1, pix}], sel_byte[{1'b0, pix}]};
    end

    assign req_ready = (state == IDLE);
    assign out_valid = (state == EMIT);
    assign out_col   = k;
    assign out_last  = (state == EMIT) && (k == 3'd7);
    assign rom_addr  = addr_q;
    assign rom_en    = en_q;

endmodule

// File: tb/tb_tile_line_fetch.sv
// Randomized self-checking bench for tile_line_fetch against a ROM model and a
// pixel reference computed directly from the tile-row byte layout.
module tb_tile_line_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_tile;
    logic [2:0]  req_row;
    logic        req_flip;
    logic [11:0] rom_addr;
    logic        rom_en;
    logic [7:0]  rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_color;
    logic [2:0]  out_col;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:4095];

    tile_line_fetch #(.TILE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tile  (req_tile),
        .req_row   (req_row),
        .req_flip  (req_flip),
        .rom_addr  (rom_addr),
        .rom_en    (rom_en),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_color (out_color),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // One-cycle registered-read tile ROM.
    always @(posedge clk) begin
        if (rom_en) rom_data <= mem[rom_addr];
    end

    task automatic check(input string tag, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
        end
    endtask

    // Colour of tile column c: byte at tile*16 + row*2 + c/4, pixel bits p and 4+p.
    function automatic int ref_color(input int tile, input int row, input int c);
        int b;
        int p;
        b = mem[tile * 16 + row * 2 + c / 4];
        p = c % 4;
        return ((b >> (4 + p)) & 1) * 2 + ((b >> p) & 1);
    endfunction

    // mode: 0 ready high, 1 long stall on beat 2 then random, 2 random,
    //       3 hold a second request (tile 0, row 5) during the row, 4 reset at beat 5
    task automatic do_row(input int tile, input int row, input int flip, input int mode);
        int exp_col [8];
        int b;
        int cyc;
        int held;
        int wait_cyc;
        for (int c = 0; c < 8; c++) exp_col[c] = ref_color(tile, row, flip ? 7 - c : c);

        wait_cyc = 0;
        while (!req_ready && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("idle_ready", int'(req_ready), 1);
        check("idle_valid", int'(out_valid), 0);
        req_valid = 1'b1;
        req_tile  = tile[7:0];
        req_row   = row[2:0];
        req_flip  = flip[0];
        @(posedge clk);
        @(negedge clk);
        if (mode == 3) begin
            req_tile = 8'h00;
            req_row  = 3'd5;
            req_flip = 1'b0;
        end else begin
            req_valid = 1'b0;
        end
        check("rd0_addr", int'(rom_addr), tile * 16 + row * 2);
        check("rd0_en", int'(rom_en), 1);
        check("rd0_ready", int'(req_ready), 0);
        @(posedge clk);
        @(negedge clk);
        check("rd1_addr", int'(rom_addr), tile * 16 + row * 2 + 1);
        check("rd1_en", int'(rom_en), 1);
        check("rd1_valid", int'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        check("cap1_en", int'(rom_en), 0);
        check("cap1_addr", int'(rom_addr), tile * 16 + row * 2 + 1);
        check("cap1_valid", int'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);

        b    = 0;
        cyc  = 0;
        held = 0;
        while (b < 8 && cyc < 200) begin
            check("emit_valid", int'(out_valid), 1);
            check("emit_ready", int'(req_ready), 0);
            check("emit_en", int'(rom_en), 0);
            check("emit_col", int'(out_col), b);
            check("emit_color", int'(out_color), exp_col[b]);
            check("emit_last", int'(out_last), (b == 7) ? 1 : 0);
            if (mode == 4 && b == 5) begin
                out_ready = 1'b0;
                if (held == 1) begin
                    rst = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    rst = 1'b0;
                    out_ready = 1'b1;
                    check("rst_valid", int'(out_valid), 0);
                    check("rst_ready", int'(req_ready), 1);
                    check("rst_en", int'(rom_en), 0);
                    check("rst_addr", int'(rom_addr), 0);
                    check("rst_color", int'(out_color), 0);
                    check("rst_col", int'(out_col), 0);
                    check("rst_last", int'(out_last), 0);
                    return;
                end
                held++;
            end else if (mode == 1 && b == 2 && held < 4) begin
                out_ready = 1'b0;
                held++;
            end else if (mode == 2 || (mode == 1 && b > 2)) begin
                out_ready = $urandom_range(0, 1) != 0;
            end else begin
                out_ready = 1'b1;
            end
            @(posedge clk);
            if (out_ready) b++;
            @(negedge clk);
            cyc++;
        end
        if (b < 8) check("emit_timeout", b, 8);
        out_ready = 1'b1;
        check("done_ready", int'(req_ready), 1);
        check("done_valid", int'(out_valid), 0);
        check("done_last", int'(out_last), 0);
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
        mem[12'h2AA] = 8'h1E;
        mem[12'h2AB] = 8'hC3;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_tile  = '0;
        req_row   = '0;
        req_flip  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_ready", int'(req_ready), 1);
        check("reset_valid", int'(out_valid), 0);
        check("reset_en", int'(rom_en), 0);
        check("reset_addr", int'(rom_addr), 0);
        check("reset_color", int'(out_color), 0);
        check("reset_col", int'(out_col), 0);
        check("reset_last", int'(out_last), 0);

        // Fixed-vector sanity of the reference itself against the known row.
        check("ref_row_c0", ref_color(8'h2A, 5, 0), 2);
        check("ref_row_c7", ref_color(8'h2A, 5, 7), 2);

        do_row(8'h2A, 5, 0, 0);
        do_row(8'h2A, 5, 1, 0);
        do_row(8'h2A, 5, 0, 1);
        do_row(8'h2A, 5, 0, 3);
        do_row(8'h00, 5, 0, 0);
        do_row(8'h2A, 5, 0, 4);
        do_row(8'h2A, 5, 0, 0);
        for (int i = 0; i < 8; i++) begin
            do_row(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 1)), 2);
        end
        do_row(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), 1, 4);
        do_row(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_line_fetch.md
# tile_line_fetch

Fetches one 8-pixel row of a 2bpp 8x8 tile from the tile ROM and streams it out as 2-bit colour indices, one pixel per accepted beat. It sits between the tilemap scan logic, which supplies tile code, pixel row and flip, and the palette/colour lookup stage. It drives the tile ROM (4 KB, 12-bit address, 8-bit data, one-cycle registered read) through `rom_addr` / `rom_en` and consumes `rom_data`.

## Interface
Parameters:
- TILE_W, 8, tile code width. ROM address width is TILE_W+4; only 8 is supported, giving a 12-bit address.

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_tile  input  TILE_W  tile code
- req_row  input  3  pixel row within tile (0..7)
- req_flip  input  1  horizontal flip for this row
- rom_addr  output  12  tile ROM address (registered)
- rom_en  output  1  tile ROM enable (registered)
- rom_data  input  8  tile ROM output; valid one cycle after address sampled
- out_valid  output  1  pixel present
- out_ready  input  1  consumer accepts pixel
- out_color  output  2  colour index
- out_col  output  3  screen-order column 0..7 of this pixel
- out_last  output  1  high on column-7 beat

## Operation
- Address: `rom_addr = {tile, row, half}`. Half 0 holds tile columns 0-3 and half 1 holds tile columns 4-7.
- Byte decode: pixel p (0..3) within a byte is `{byte[4+p], byte[p]}`. Tile column c = 4*half + p.
- The request handshake completes on `req_valid && req_ready`. Tile, row and flip are latched on that edge.
- FSM states: IDLE, RD0, RD1, CAP1, EMIT.
  - IDLE: `req_ready=1`. On handshake go to RD0 with `rom_addr={tile,row,0}` and `rom_en=1`.
  - RD0: ROM samples half-0 address. Go to RD1 with `rom_addr={tile,row,1}` and `rom_en=1`.
  - RD1: capture `rom_data` (byte 0) into buf0. Go to CAP1. Set `rom_en=0` (hold `rom_addr`).
  - CAP1: capture `rom_data` (byte 1) into buf1. Go to EMIT with column counter k=0.
  - EMIT: `out_valid=1`.
    - Pixel column is c = flip ? 7-k : k, and `out_color` is decoded tile column c.
    - `out_col=k` and `out_last=(k==7)`.
    - k increments only on `out_valid && out_ready`. When the k==7 beat transfers, go to IDLE.
- `req_ready=0` in every state except IDLE. `req_valid` outside IDLE is ignored, with no queuing.
- While `out_ready=0`, `out_color`, `out_col` and `out_last` hold stable and `out_valid` stays high.
- Reset (any state, including mid-EMIT with backpressure): next state IDLE. Outputs after the reset edge:
  - `req_ready=1`, `out_valid=0`, `out_last=0`
  - `rom_en=0`, `rom_addr=0`
  - `out_color=0`, `out_col=0`
  - buf0 and buf1 cleared.
- The in-flight row is discarded on reset and no partial pixels are emitted afterward.

## Timing
- Request accepted at edge E0.
- `rom_addr` half 0 is valid after E0 and half 1 after E1.
- buf0 is captured at E2 and buf1 at E3.
- `out_valid` rises after E3, so first pixel latency is 3 cycles from accept.
- With `out_ready` held high, 8 pixels take 8 cycles (E3..E10). `req_ready` is high after E11, the k==7 transfer edge.
- Minimum request period is 12 cycles. Backpressure only extends EMIT.
- `rom_en` is high for exactly 2 cycles per request.
- The ROM data-return wait is fixed at 1 cycle. No other latency is supported.

## Test plan
- ROM model: address 0x2AA=0x1E, address 0x2AB=0xC3.
- Request tile=0x2A, row=5, flip=0, `out_ready` high:
  - `rom_addr` sequence is 0x2AA then 0x2AB.
  - `out_color` = 2,1,1,1,1,1,2,2 on consecutive cycles starting 3 cycles after accept.
  - `out_last` is high only on the 8th beat, and `req_ready` returns the following cycle.
- Same request with flip=1 -> colours 2,2,1,1,1,1,1,2, with `out_col` still 0..7.
- Flip=0 with `out_ready` low for 4 cycles on beat 2 and random toggling afterward:
  - the same 8-value sequence completes with no drops or duplicates;
  - outputs stay stable while stalled.
- Assert `req_valid` continuously with a second request (tile 0x00) during EMIT:
  - `req_ready` stays 0 during EMIT;
  - the second request is accepted only in IDLE;
  - its `rom_addr` is 0x00A then 0x00B.
- Assert `rst` for 1 cycle while stalled at k=5:
  - next cycle `out_valid=0`, `req_ready=1`, `rom_en=0`;
  - a following request produces a clean 8-pixel row.
